// File: rtl/mips_prog_loader.sv
// Byte-stream program loader: parses framed load/run commands, assembles
// little-endian 32-bit words, writes them to IMEM/DMEM, then releases the CPU
// and flags completion when the PC reaches the halt address.
module mips_prog_loader #(
  parameter int unsigned ADDR_W  = 10,
  parameter logic [31:0] HALT_PC = 32'd136
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [7:0]        in_data,
  output logic              wr_en,
  output logic              wr_sel,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [31:0]       wr_data,
  output logic              cpu_hold,
  input  logic [31:0]       pc,
  output logic              done,
  output logic              err
);

  typedef enum logic [2:0] {
    S_IDLE, S_ADDR_HI, S_ADDR_LO, S_CNT_HI, S_CNT_LO, S_DATA, S_CHK, S_RUN
  } state_t;

  state_t              state, state_nxt;
  logic                accept;
  logic                is_load;
  logic [7:0]          hi_byte;     // holds ADDR_HI, then CNT_HI
  logic [7:0]          chk;         // running XOR from CMD onward
  logic [15:0]         words_left;
  logic [1:0]          byte_idx;
  logic [23:0]         part;        // lower three bytes of the word in progress
  logic [ADDR_W-1:0]   waddr;       // address of the next word to be written

  // Only RUN refuses bytes; the CPU is held in reset everywhere else.
  assign in_ready = (state != S_RUN);
  assign cpu_hold = (state != S_RUN);
  assign accept   = in_valid && (state != S_RUN);
  assign is_load  = (in_data == 8'h01) || (in_data == 8'h02);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Next-state decode from the accepted byte.
  always_comb begin
    state_nxt = state;
    if (accept) begin
      unique case (state)
        S_IDLE: begin
          if (is_load)                     state_nxt = S_ADDR_HI;
          else if (in_data == 8'h03 && !err) state_nxt = S_RUN;
        end
        S_ADDR_HI: state_nxt = S_ADDR_LO;
        S_ADDR_LO: state_nxt = S_CNT_HI;
        S_CNT_HI:  state_nxt = S_CNT_LO;
        S_CNT_LO:  state_nxt = ({hi_byte, in_data} != 16'd0) ? S_DATA : S_CHK;
        S_DATA:    if (byte_idx == 2'd3 && words_left == 16'd1) state_nxt = S_CHK;
        S_CHK:     state_nxt = S_IDLE;
        S_RUN:     state_nxt = S_RUN;
        default:   state_nxt = S_IDLE;
      endcase
    end
  end

  // Frame datapath: header capture, word assembly, write strobe, checksum.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_en      <= 1'b0;
      wr_sel     <= 1'b0;
      wr_addr    <= '0;
      wr_data    <= '0;
      done       <= 1'b0;
      err        <= 1'b0;
      hi_byte    <= '0;
      chk        <= '0;
      words_left <= '0;
      byte_idx   <= '0;
      part       <= '0;
      waddr      <= '0;
    end else begin
      wr_en <= 1'b0;
      if (accept) begin
        unique case (state)
          S_IDLE: begin
            if (is_load) begin
              wr_sel <= (in_data == 8'h02);
              chk    <= in_data;
            end else begin
              chk <= '0;
              if (in_data != 8'h03) err <= 1'b1;
            end
          end
          S_ADDR_HI: begin
            hi_byte <= in_data;
            chk     <= chk ^ in_data;
          end
          S_ADDR_LO: begin
            // Truncation here gives the modulo-2^ADDR_W wrap for free.
            waddr <= ADDR_W'({hi_byte, in_data});
            chk   <= chk ^ in_data;
          end
          S_CNT_HI: begin
            hi_byte <= in_data;
            chk     <= chk ^ in_data;
          end
          S_CNT_LO: begin
            words_left <= {hi_byte, in_data};
            byte_idx   <= '0;
            chk        <= chk ^ in_data;
          end
          S_DATA: begin
            chk      <= chk ^ in_data;
            byte_idx <= byte_idx + 2'd1;
            unique case (byte_idx)
              2'd0: part[7:0]   <= in_data;
              2'd1: part[15:8]  <= in_data;
              2'd2: part[23:16] <= in_data;
              default: begin
                wr_en      <= 1'b1;
                wr_data    <= {in_data, part};
                wr_addr    <= waddr;
                waddr      <= waddr + ADDR_W'(1);
                words_left <= words_left - 16'd1;
              end
            endcase
          end
          S_CHK: begin
            if (in_data != chk) err <= 1'b1;
            chk <= '0;
          end
          default: ;
        endcase
      end
      if (state == S_RUN && pc == HALT_PC) done <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mips_prog_loader.sv
// Randomized self-checking bench for mips_prog_loader with a frame-level model.
module tb_mips_prog_loader;

  localparam int unsigned AW   = 10;
  localparam logic [31:0] HALT = 32'd136;

  logic          clk;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [7:0]    in_data;
  logic          wr_en;
  logic          wr_sel;
  logic [AW-1:0] wr_addr;
  logic [31:0]   wr_data;
  logic          cpu_hold;
  logic [31:0]   pc;
  logic          done;
  logic          err;

  mips_prog_loader #(.ADDR_W(AW), .HALT_PC(HALT)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .wr_en(wr_en), .wr_sel(wr_sel), .wr_addr(wr_addr),
    .wr_data(wr_data), .cpu_hold(cpu_hold), .pc(pc), .done(done), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic          exp_sel[$];
  logic [AW-1:0] exp_addr[$];
  logic [31:0]   exp_data[$];
  logic [31:0]   wbuf[16];
  bit            gaps;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%h expected=%h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Every observed write must match the next one the model predicted.
  always @(negedge clk) begin
    if (rst_n && wr_en) begin
      if (exp_data.size() == 0) begin
        check("spurious_wr_en", 32'(wr_en), 32'd0);
      end else begin
        check("wr_sel", 32'(wr_sel), 32'(exp_sel.pop_front()));
        check("wr_addr", 32'(wr_addr), 32'(exp_addr.pop_front()));
        check("wr_data", wr_data, exp_data.pop_front());
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  task automatic send_byte(input logic [7:0] b);
    int ng;
    ng = gaps ? int'($urandom_range(0, 2)) : 0;
    repeat (ng) begin @(posedge clk); #1; end
    in_valid = 1'b1;
    in_data  = b;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_data  = 8'($urandom);
  endtask

  // Model: word i of a frame lands at (addr + i) mod 2^AW with the frame's
  // memory select; checksum is the XOR of all bytes before CHK.
  task automatic send_frame(input logic [7:0] cmd, input logic [15:0] addr,
                            input logic [15:0] cnt, input bit bad);
    logic [7:0]  c;
    logic [31:0] a;
    logic [31:0] w;
    c = cmd ^ addr[15:8] ^ addr[7:0] ^ cnt[15:8] ^ cnt[7:0];
    for (int i = 0; i < int'(cnt); i++) begin
      a = (32'(addr) + 32'(i)) % (32'd1 << AW);
      exp_sel.push_back(cmd == 8'h02);
      exp_addr.push_back(a[AW-1:0]);
      exp_data.push_back(wbuf[i]);
    end
    send_byte(cmd);
    send_byte(addr[15:8]);
    send_byte(addr[7:0]);
    send_byte(cnt[15:8]);
    send_byte(cnt[7:0]);
    for (int i = 0; i < int'(cnt); i++) begin
      w = wbuf[i];
      for (int k = 0; k < 4; k++) begin
        c = c ^ w[7:0];
        send_byte(w[7:0]);
        w = w >> 8;
      end
    end
    send_byte(bad ? (c ^ 8'h5A) : c);
  endtask

  task automatic fill_random(input int n);
    for (int i = 0; i < n; i++) wbuf[i] = $urandom;
  endtask

  task automatic drain();
    repeat (4) @(posedge clk);
    #1;
    check("pending_writes", 32'(exp_data.size()), 32'd0);
  endtask

  task automatic check_reset_vals();
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_wr_en", 32'(wr_en), 32'd0);
    check("rst_wr_sel", 32'(wr_sel), 32'd0);
    check("rst_wr_addr", 32'(wr_addr), 32'd0);
    check("rst_wr_data", wr_data, 32'd0);
    check("rst_cpu_hold", 32'(cpu_hold), 32'd1);
    check("rst_done", 32'(done), 32'd0);
    check("rst_err", 32'(err), 32'd0);
  endtask

  task automatic do_reset();
    rst_n    = 1'b0;
    in_valid = 1'b0;
    #2;
    check_reset_vals();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_data = 8'h00; pc = 32'd0; gaps = 1'b0;
    #12;
    check_reset_vals();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Directed IMEM load of two words.
    wbuf[0] = 32'h12345678;
    wbuf[1] = 32'hDEADBEEF;
    send_frame(8'h01, 16'h0010, 16'd2, 1'b0);
    drain();
    check("err_after_imem", 32'(err), 32'd0);

    // DMEM load wrapping past the top of the address space.
    fill_random(2);
    send_frame(8'h02, 16'h03FF, 16'd2, 1'b0);
    drain();
    check("err_after_wrap", 32'(err), 32'd0);

    // 3-word load with random bubbles, then random frames with bubbles.
    gaps = 1'b1;
    fill_random(3);
    send_frame(8'h01, 16'h0100, 16'd3, 1'b0);
    drain();
    for (int f = 0; f < 5; f++) begin
      fill_random(4);
      send_frame(8'($urandom_range(1, 2)), 16'($urandom), 16'($urandom_range(1, 4)), 1'b0);
      drain();
    end
    gaps = 1'b0;
    check("err_after_random", 32'(err), 32'd0);
    check("hold_while_loading", 32'(cpu_hold), 32'd1);

    // Reset after two of four data bytes: nothing written, outputs cleared.
    send_byte(8'h01); send_byte(8'h00); send_byte(8'h05);
    send_byte(8'h00); send_byte(8'h01);
    send_byte(8'hAA); send_byte(8'hBB);
    do_reset();
    fill_random(1);
    send_frame(8'h01, 16'h0005, 16'd1, 1'b0);
    drain();

    // Unknown command sets err; loading still works afterwards.
    send_byte(8'h07);
    check("err_bad_cmd", 32'(err), 32'd1);
    check("ready_after_bad_cmd", 32'(in_ready), 32'd1);
    fill_random(2);
    send_frame(8'h02, 16'($urandom), 16'd2, 1'b0);
    drain();
    check("err_sticky", 32'(err), 32'd1);

    // Bad checksum: writes still happen, err set, run command refused.
    do_reset();
    fill_random(1);
    send_frame(8'h01, 16'h0020, 16'd1, 1'b1);
    drain();
    check("err_bad_chk", 32'(err), 32'd1);
    send_byte(8'h03);
    check("hold_run_refused", 32'(cpu_hold), 32'd1);
    check("ready_run_refused", 32'(in_ready), 32'd1);

    // Empty frame then run; done on the halt PC.
    do_reset();
    send_frame(8'h01, 16'h0000, 16'd0, 1'b0);
    drain();
    check("err_cnt0", 32'(err), 32'd0);
    send_byte(8'h03);
    check("hold_in_run", 32'(cpu_hold), 32'd0);
    check("ready_in_run", 32'(in_ready), 32'd0);
    pc = 32'd132;
    @(posedge clk); #1;
    check("done_before_halt", 32'(done), 32'd0);
    pc = 32'd136;
    @(posedge clk); #1;
    check("done_at_halt", 32'(done), 32'd1);
    pc = 32'd140;
    repeat (3) @(posedge clk);
    #1;
    check("done_sticky", 32'(done), 32'd1);
    check("hold_stays_low", 32'(cpu_hold), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
